// File: rtl/spi_flash_loader_pkg.sv
`default_nettype none
// spi_flash_loader_pkg -- SPI register map, ctrl field positions and helpers shared with the SPI peripheral.
// Rev 1.0
package spi_flash_loader_pkg;

  typedef enum logic [1:0] {
    DATAREG = 2'd0,
    IMMDATA = 2'd1,
    CTRLREG = 2'd2
  } spi_reg_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE  = 2'd0,
    WIDTH_HALF  = 2'd1,
    WIDTH_TRIPLE = 2'd2,
    WIDTH_WORD  = 2'd3
  } spi_width_e;

  localparam int CTRL_WIDTH_LSB     = 0;
  localparam int CTRL_SS_LSB        = 8;
  localparam int CTRL_ENDIAN_BIT    = 16;
  localparam int CTRL_SS_ACTIVE_BIT = 24;

  localparam logic [7:0] FLASH_READ = 8'h03;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // 32-bit, big-endian shifting, chosen slave selected.
  function automatic logic [31:0] cfg_word(input logic [1:0] ss);
    logic [31:0] w;
    w = 32'd0;
    w[CTRL_WIDTH_LSB +: 2]   = WIDTH_WORD;
    w[CTRL_SS_LSB +: 2]      = ss;
    w[CTRL_ENDIAN_BIT]       = 1'b1;
    w[CTRL_SS_ACTIVE_BIT]    = 1'b1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_loader_if.sv
`default_nettype none
// spi_flash_loader_if -- SPI register port and RAM write port driven by the loader.
// Rev 1.0
interface spi_flash_loader_if;
  logic        spi_select;
  logic [3:0]  spi_we;
  logic        spi_rd;
  logic [1:0]  spi_addr;
  logic [31:0] spi_wdata;
  logic [31:0] spi_rdata;
  logic        spi_wbusy;
  logic        spi_rbusy;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wbusy;

  modport master (
    output spi_select, spi_we, spi_rd, spi_addr, spi_wdata,
    output mem_we, mem_addr, mem_wdata,
    input  spi_rdata, spi_wbusy, spi_rbusy, mem_wbusy
  );

  modport slave (
    input  spi_select, spi_we, spi_rd, spi_addr, spi_wdata,
    input  mem_we, mem_addr, mem_wdata,
    output spi_rdata, spi_wbusy, spi_rbusy, mem_wbusy
  );
endinterface
`default_nettype wire

// File: rtl/spi_flash_loader.sv
`default_nettype none
// spi_flash_loader -- issues a flash READ through the SPI register port and copies N words into RAM.
// Rev 1.0
module spi_flash_loader
  import spi_flash_loader_pkg::*;
#(
  parameter int         SS_INDEX  = 0,
  parameter logic [7:0] READ_CMD  = FLASH_READ,
  parameter bit         BYTE_SWAP = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [23:0]               flash_addr,
  input  logic [31:0]               dest_addr,
  input  logic [15:0]               word_count,
  output logic                      busy,
  output logic                      done,
  spi_flash_loader_if.master        bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_CMDLD = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_MEMWR = 3'd5,
    ST_DESEL = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam logic [1:0]  SS_SEL   = 2'(SS_INDEX);
  localparam logic [31:0] CFG_WORD = cfg_word(SS_SEL);

  state_t      state, state_nxt;
  logic [23:0] flash_base;
  logic [31:0] dest_base;
  logic [15:0] count;
  logic [15:0] idx;
  logic        cmd_phase;
  logic        wait_first;

  logic [15:0] idx_inc;
  logic [31:0] rx_word;
  logic [31:0] mem_addr_cur;
  logic        xfer_ready;

  logic        sel_nxt, rd_nxt, busy_nxt, done_nxt;
  logic [3:0]  we_nxt, mem_we_nxt;
  logic [1:0]  addr_nxt;
  logic [31:0] wdata_nxt, mem_addr_nxt, mem_wdata_nxt;

  assign idx_inc      = idx + 16'd1;
  assign rx_word      = BYTE_SWAP ? byte_swap(bus.spi_rdata) : bus.spi_rdata;
  assign mem_addr_cur = (dest_base & 32'hFFFF_FFFC) + {14'd0, idx, 2'b00};
  // rbusy rises one cycle after the read strobe, so the first WAIT cycle is never trusted.
  assign xfer_ready   = !wait_first && !bus.spi_rbusy;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (word_count == 16'd0) ? ST_DONE : ST_CFG;
      ST_CFG:   if (!bus.spi_wbusy) state_nxt = ST_CMDLD;
      ST_CMDLD: if (!bus.spi_wbusy) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (xfer_ready) state_nxt = cmd_phase ? ST_ISSUE : ST_MEMWR;
      ST_MEMWR: if (!bus.mem_wbusy) state_nxt = (idx_inc == count) ? ST_DESEL : ST_ISSUE;
      ST_DESEL: if (!bus.spi_wbusy) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change with the state.
  always_comb begin
    sel_nxt       = 1'b0;
    rd_nxt        = 1'b0;
    we_nxt        = 4'b0000;
    addr_nxt      = DATAREG;
    wdata_nxt     = 32'd0;
    mem_we_nxt    = 4'b0000;
    mem_addr_nxt  = 32'd0;
    mem_wdata_nxt = 32'd0;
    busy_nxt      = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
    done_nxt      = (state_nxt == ST_DONE);
    case (state_nxt)
      ST_CFG: begin
        sel_nxt   = 1'b1;
        we_nxt    = 4'b1111;
        addr_nxt  = CTRLREG;
        wdata_nxt = CFG_WORD;
      end
      ST_CMDLD: begin
        sel_nxt   = 1'b1;
        we_nxt    = 4'b1111;
        addr_nxt  = IMMDATA;
        wdata_nxt = {READ_CMD, flash_base};
      end
      ST_ISSUE: begin
        sel_nxt = 1'b1;
        rd_nxt  = 1'b1;
      end
      ST_WAIT: sel_nxt = 1'b1;
      ST_MEMWR: begin
        mem_we_nxt    = 4'b1111;
        mem_addr_nxt  = mem_addr_cur;
        mem_wdata_nxt = (state == ST_WAIT) ? rx_word : bus.mem_wdata;
      end
      ST_DESEL: begin
        sel_nxt  = 1'b1;
        we_nxt   = 4'b1000;
        addr_nxt = CTRLREG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      flash_base     <= 24'd0;
      dest_base      <= 32'd0;
      count          <= 16'd0;
      idx            <= 16'd0;
      cmd_phase      <= 1'b0;
      wait_first     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.spi_select <= 1'b0;
      bus.spi_rd     <= 1'b0;
      bus.spi_we     <= 4'b0000;
      bus.spi_addr   <= 2'd0;
      bus.spi_wdata  <= 32'd0;
      bus.mem_we     <= 4'b0000;
      bus.mem_addr   <= 32'd0;
      bus.mem_wdata  <= 32'd0;
    end else begin
      state          <= state_nxt;
      wait_first     <= (state == ST_ISSUE);
      busy           <= busy_nxt;
      done           <= done_nxt;
      bus.spi_select <= sel_nxt;
      bus.spi_rd     <= rd_nxt;
      bus.spi_we     <= we_nxt;
      bus.spi_addr   <= addr_nxt;
      bus.spi_wdata  <= wdata_nxt;
      bus.mem_we     <= mem_we_nxt;
      bus.mem_addr   <= mem_addr_nxt;
      bus.mem_wdata  <= mem_wdata_nxt;
      if (state == ST_IDLE && start && word_count != 16'd0) begin
        flash_base <= flash_addr;
        dest_base  <= dest_addr;
        count      <= word_count;
        idx        <= 16'd0;
        cmd_phase  <= 1'b1;
      end
      if (state == ST_WAIT && xfer_ready) cmd_phase <= 1'b0;
      if (state == ST_MEMWR && !bus.mem_wbusy) idx <= idx_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_loader.sv
`default_nettype none
// tb_spi_flash_loader -- directed bench: two loaders (byte-swapped and raw) in lockstep on one SPI/flash model.
// Rev 1.0
module tb_spi_flash_loader;
  import spi_flash_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] fa = 24'd0;
  logic [31:0] da = 32'd0;
  logic [15:0] wc = 16'd0;
  logic        mem_wb = 1'b0;
  logic        busy0, done0, busy1, done1;

  spi_flash_loader_if bus0 ();
  spi_flash_loader_if bus1 ();

  spi_flash_loader #(.SS_INDEX(2), .BYTE_SWAP(1'b1)) dut0 (
    .clk(clk), .reset(rst), .start(start), .flash_addr(fa), .dest_addr(da),
    .word_count(wc), .busy(busy0), .done(done0), .bus(bus0)
  );
  spi_flash_loader #(.SS_INDEX(2), .BYTE_SWAP(1'b0)) dut1 (
    .clk(clk), .reset(rst), .start(start), .flash_addr(fa), .dest_addr(da),
    .word_count(wc), .busy(busy1), .done(done1), .bus(bus1)
  );

  initial forever #5 clk = ~clk;

  // SPI peripheral + flash model (flash byte at address a is a[7:0])
  logic [31:0] ctrl, shreg, resp, m_rdata;
  logic        m_rbusy, pend, cmd_done;
  logic [5:0]  bitcnt;
  logic [23:0] faddr;
  logic [3:0]  ss_n;

  assign bus0.spi_rdata = m_rdata;
  assign bus1.spi_rdata = m_rdata;
  assign bus0.spi_rbusy = m_rbusy;
  assign bus1.spi_rbusy = m_rbusy;
  assign bus0.spi_wbusy = 1'b0;
  assign bus1.spi_wbusy = 1'b0;
  assign bus0.mem_wbusy = mem_wb;
  assign bus1.mem_wbusy = mem_wb;
  assign ss_n = ctrl[CTRL_SS_ACTIVE_BIT] ? ~(4'b0001 << ctrl[9:8]) : 4'b1111;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    logic [7:0] b0;
    b0 = a[7:0];
    return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= 32'd0; shreg <= 32'd0; resp <= 32'd0; m_rdata <= 32'd0;
      m_rbusy <= 1'b0; pend <= 1'b0; cmd_done <= 1'b0; bitcnt <= 6'd0; faddr <= 24'd0;
    end else begin
      if (bus0.spi_select && bus0.spi_we != 4'b0000) begin
        if (bus0.spi_addr == CTRLREG) begin
          for (int b = 0; b < 4; b++)
            if (bus0.spi_we[b]) ctrl[8*b +: 8] <= bus0.spi_wdata[8*b +: 8];
          if (bus0.spi_we[3] && !bus0.spi_wdata[CTRL_SS_ACTIVE_BIT]) cmd_done <= 1'b0;
        end else if (bus0.spi_addr == IMMDATA) begin
          shreg <= bus0.spi_wdata;
        end
      end
      if (bus0.spi_select && bus0.spi_rd && bus0.spi_addr == DATAREG) begin
        pend <= 1'b1;
        if (!cmd_done) begin
          cmd_done <= 1'b1;
          faddr    <= shreg[23:0];
          resp     <= 32'hFFFF_FFFF;
        end else begin
          resp  <= flash_word(faddr);
          faddr <= faddr + 24'd4;
        end
      end
      if (pend) begin
        pend <= 1'b0; m_rbusy <= 1'b1; bitcnt <= 6'd31; m_rdata <= 32'hDEAD_BEEF;
      end else if (m_rbusy) begin
        if (bitcnt == 6'd0) begin
          m_rbusy <= 1'b0; m_rdata <= resp;
        end else begin
          bitcnt <= bitcnt - 6'd1;
        end
      end
    end
  end

  // Logs: MOSI word at each transfer start, RAM writes per DUT, done pulses, cycles
  logic [31:0] mosi_log [0:63];
  logic [31:0] wa0 [0:63], wd0 [0:63], wa1 [0:63], wd1 [0:63];
  int mosi_n = 0, wn0 = 0, wn1 = 0, dc0 = 0, cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done0) dc0 <= dc0 + 1;
    if (!rst && bus0.spi_select && bus0.spi_rd && bus0.spi_addr == DATAREG && mosi_n < 64) begin
      mosi_log[mosi_n] <= shreg;
      mosi_n <= mosi_n + 1;
    end
    if (bus0.mem_we == 4'hF && !mem_wb && wn0 < 64) begin
      wa0[wn0] <= bus0.mem_addr; wd0[wn0] <= bus0.mem_wdata; wn0 <= wn0 + 1;
    end
    if (bus1.mem_we == 4'hF && !mem_wb && wn1 < 64) begin
      wa1[wn1] <= bus1.mem_addr; wd1[wn1] <= bus1.mem_wdata; wn1 <= wn1 + 1;
    end
  end

  int n_cmp = 0, n_fail = 0;
  int t0, lat, lat_base, m0, w0, w1, d0;
  logic [31:0] snap_a, snap_d;
  logic sel_seen, busy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [23:0] f, input logic [31:0] d, input logic [15:0] c);
    step();
    m0 = mosi_n; w0 = wn0; w1 = wn1; d0 = dc0;
    fa = f; da = d; wc = c; start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, output int l);
    int n;
    n = 0;
    while (!done0 && n < 3000) begin step(); n++; end
    check(tag, {31'd0, done0}, 32'd1);
    l = cyc - t0;
  endtask

  task automatic wait_memwr(input string tag);
    int n;
    n = 0;
    while (bus0.mem_we != 4'hF && n < 300) begin step(); n++; end
    check(tag, {28'd0, bus0.mem_we}, 32'hF);
  endtask

  initial begin
    // reset state
    repeat (3) step();
    check("rst_ctl", {26'd0, busy0, done0, bus0.spi_select, bus0.spi_rd, bus0.spi_addr}, 32'd0);
    check("rst_we", {24'd0, bus0.spi_we, bus0.mem_we}, 32'd0);
    check("rst_maddr", bus0.mem_addr, 32'd0);
    check("rst_wdata", bus0.spi_wdata, 32'd0);
    rst = 1'b0;

    // basic two-word load
    launch(24'h000010, 32'h0000_1000, 16'd2);
    repeat (10) step();
    check("t1_busy", {31'd0, busy0}, 32'd1);
    check("t1_ss_on", {28'd0, ss_n}, 32'hB);
    wait_done("t1_done", lat_base);
    check("t1_cmd", mosi_log[m0], 32'h0300_0010);
    check("t1_nxfer", mosi_n - m0, 32'd3);
    check("t1_nwr", wn0 - w0, 32'd2);
    check("t1_a0", wa0[w0], 32'h0000_1000);
    check("t1_d0", wd0[w0], 32'h1312_1110);
    check("t1_a1", wa0[w0+1], 32'h0000_1004);
    check("t1_d1", wd0[w0+1], 32'h1716_1514);
    check("t1_raw0", wd1[w1], 32'h1011_1213);
    check("t1_raw1", wd1[w1+1], 32'h1415_1617);
    check("t1_busy_at_done", {31'd0, busy0}, 32'd0);
    step();
    check("t1_done_pulse", {30'd0, done0, busy0}, 32'd0);
    check("t1_ss_off", {28'd0, ss_n}, 32'hF);
    check("t1_ndone", dc0 - d0, 32'd1);

    // zero words
    launch(24'h000055, 32'h0000_7000, 16'd0);
    check("t2_done_next", {31'd0, done0}, 32'd1);
    sel_seen = bus0.spi_select; busy_seen = busy0;
    repeat (6) begin step(); sel_seen |= bus0.spi_select; busy_seen |= busy0; end
    check("t2_nosel", {31'd0, sel_seen}, 32'd0);
    check("t2_nobusy", {31'd0, busy_seen}, 32'd0);
    check("t2_nowr", wn0 - w0, 32'd0);
    check("t2_ndone", dc0 - d0, 32'd1);

    // RAM stall of 5 cycles on the first word
    launch(24'h000010, 32'h0000_2000, 16'd2);
    wait_memwr("t3_memwr");
    mem_wb = 1'b1;
    snap_a = bus0.mem_addr; snap_d = bus0.mem_wdata;
    repeat (5) begin
      step();
      check("t3_hold_we", {28'd0, bus0.mem_we}, 32'hF);
      check("t3_hold_a", bus0.mem_addr, snap_a);
      check("t3_hold_d", bus0.mem_wdata, snap_d);
    end
    mem_wb = 1'b0;
    wait_done("t3_done", lat);
    check("t3_latency", lat, lat_base + 5);
    check("t3_nwr", wn0 - w0, 32'd2);
    check("t3_a0", wa0[w0], 32'h0000_2000);
    check("t3_d0", wd0[w0], 32'h1312_1110);
    check("t3_d1", wd0[w0+1], 32'h1716_1514);

    // reset during the second word
    launch(24'h000010, 32'h0000_3000, 16'd2);
    wait_memwr("t4_memwr");
    repeat (15) step();
    d0 = dc0;
    rst = 1'b1;
    #1;
    check("t4_rst_ctl", {26'd0, busy0, done0, bus0.spi_select, bus0.spi_rd, bus0.spi_addr}, 32'd0);
    check("t4_rst_we", {24'd0, bus0.spi_we, bus0.mem_we}, 32'd0);
    check("t4_rst_ss", {28'd0, ss_n}, 32'hF);
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();
    check("t4_nodone", dc0 - d0, 32'd0);
    check("t4_onewr", wn0 - w0, 32'd1);
    launch(24'h000020, 32'h0000_4000, 16'd1);
    wait_done("t4_done", lat);
    check("t4_cmd", mosi_log[m0], 32'h0300_0020);
    check("t4_a0", wa0[w0], 32'h0000_4000);
    check("t4_d0", wd0[w0], 32'h2322_2120);
    check("t4_raw0", wd1[w1], 32'h2021_2223);

    // start while busy is ignored; low address bits dropped
    launch(24'h000040, 32'h0000_5003, 16'd1);
    repeat (10) step();
    fa = 24'h000080; da = 32'h0000_6000; wc = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t5_done", lat);
    check("t5_cmd", mosi_log[m0], 32'h0300_0040);
    check("t5_a0", wa0[w0], 32'h0000_5000);
    check("t5_d0", wd0[w0], 32'h4342_4140);
    repeat (80) step();
    check("t5_nwr", wn0 - w0, 32'd1);
    check("t5_ndone", dc0 - d0, 32'd1);
    check("t5_idle", {31'd0, busy0}, 32'd0);

    // destination wraps past 2^32
    launch(24'h000000, 32'hFFFF_FFFE, 16'd2);
    wait_done("t6_done", lat);
    check("t6_a0", wa0[w0], 32'hFFFF_FFFC);
    check("t6_d0", wd0[w0], 32'h0302_0100);
    check("t6_a1", wa0[w0+1], 32'h0000_0000);
    check("t6_d1", wd0[w0+1], 32'h0706_0504);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
